// File: rtl/cla_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_serial_adder
//
// Digit-serial adder: sums two WIDTH-bit operands two bits per clock through a
// single 2-bit carry-lookahead slice (cla_2) and a registered inter-digit
// carry. Trades latency (WIDTH/2 cycles) for a short combinational path.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair on a/b/cin is valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry into digit 0
//   out_valid  s/cout (and ovf) hold a completed result
//   out_ready  consumer accepts the result
//   s          WIDTH-bit sum
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (only when CLA_SERIAL_OVF_EN is defined)
//
// Optional feature macro: CLA_SERIAL_OVF_EN adds the ovf port and its logic.
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for an operand pair; in_ready = 1
//   RUN   | one digit computed per cycle, k = 0 .. WIDTH/2-1
//   DONE  | result held on s/cout until out_ready
// -----------------------------------------------------------------------------

// 2-bit carry-lookahead slice.
module cla_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);
    logic [1:0] g;
    logic [1:0] p;
    logic       c1;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c1   = g[0] | (p[0] & cin);
    assign cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign s    = p ^ {c1, cin};
endmodule

module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int DIGITS = WIDTH / 2;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("cla_serial_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry;
    logic [KW-1:0]    k;
    logic [KW:0]      idx;
    logic [1:0]       dig_a;
    logic [1:0]       dig_b;
    logic [1:0]       dig_s;
    logic             dig_cout;
    logic             accept;
    logic             digit_last;

    assign accept     = (state == IDLE) && in_valid;
    assign digit_last = (state == RUN) && (k == K_LAST);

    // Bit offset of the current digit is 2k.
    assign idx   = {k, 1'b0};
    assign dig_a = a_reg[idx +: 2];
    assign dig_b = b_reg[idx +: 2];

    cla_2 u_cla_2 (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry),
        .s    (dig_s),
        .cout (dig_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)   state_next = RUN;
            RUN:  if (k == K_LAST) state_next = DONE;
            DONE: if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            k     <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            k     <= '0;
        end else if (state == RUN) begin
            s_reg[idx +: 2] <= dig_s;
            carry           <= dig_cout;
            k               <= k + KW'(1);
        end
    end

`ifdef CLA_SERIAL_OVF_EN
    logic ovf_reg;

    // Carry into the MSB is recovered from the MSB sum bit of the last digit;
    // signed overflow is that carry XOR the carry out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (digit_last) begin
            ovf_reg <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ dig_s[1]) ^ dig_cout;
        end
    end

    assign ovf = ovf_reg;
`else
    logic unused_last;
    assign unused_last = digit_last;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = s_reg;
    assign cout      = carry;
endmodule

// File: doc/cla_serial_adder.md
# cla_serial_adder

Multi-cycle, digit-serial adder that sums two WIDTH-bit operands 2 bits per clock using one `cla_2` slice and a registered inter-digit carry. It sits in front of downstream consumers that can tolerate latency in exchange for area. It accepts operand pairs over a valid/ready handshake and presents the full-width sum and carry-out over a second valid/ready handshake. It is the sequential wrapper that feeds the 2-bit CLA cell and consumes its per-digit sum and carry.

## Interface
Clocking and reset: one clock; reset is synchronous and active-low.

Parameters:
- WIDTH, 16, operand/sum width. Must be even and ≥ 2; an odd value or a value < 2 is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair on a/b/cin is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to digit 0.
- out_valid  output  1  s/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow. Present only with CLA_SERIAL_OVF_EN.

## Operation
- The FSM has three states: IDLE, RUN and DONE. The reset state is IDLE.
- in_ready = (state == IDLE). It is purely a decode of the state register.
- **IDLE:**
  - If in_valid && in_ready, the block registers a, b and cin into the operand and carry registers.
  - It clears the digit counter k to 0.
  - It moves to RUN.
- **RUN:**
  - Each cycle it drives the cla_2 instance with a[2k+1:2k], b[2k+1:2k] and the carry register.
  - It writes the slice sum into s_reg[2k+1:2k] and the slice cout into the carry register.
  - It then increments k.
  - After digit k = WIDTH/2-1 is written, it moves to DONE.
- **DONE:**
  - out_valid = 1.
  - s = s_reg and cout = carry register; both are held stable.
  - On out_ready it returns to IDLE.
- The result equals {cout, s} = a + b + cin, computed modulo 2^(WIDTH+1).
- in_valid asserted outside IDLE is ignored. Upstream must hold the operands until the handshake completes.
- The operand registers are loaded only on acceptance. Changes on a/b after acceptance do not affect the result in flight.
- Reset mid-operation (RUN or DONE) aborts the operation with no partial result. The next cycle is IDLE with every output at its reset value.
- Reset values:
  - out_valid = 0
  - s = 0
  - cout = 0
  - ovf = 0
  - in_ready = 1 once state is IDLE.

## Timing
- Let the acceptance edge be E0. The digits are computed on edges E1 … E(WIDTH/2). out_valid rises after edge E(WIDTH/2).
- Latency is WIDTH/2 cycles from acceptance to out_valid.
- If out_ready is high when out_valid rises, the result is consumed on the next edge and the block is in IDLE one cycle later. in_ready is high in that cycle.
- Minimum initiation interval is WIDTH/2 + 2 cycles: accept, WIDTH/2 RUN cycles, one DONE cycle.
- Back-pressure: DONE holds indefinitely while out_ready = 0, with s/cout/ovf unchanged.
- The combinational path per cycle is one cla_2 plus a mux for the 2-bit digit select. There is no full-width carry chain.
- No output depends combinationally on any input.

## Configuration
- CLA_SERIAL_OVF_EN is undefined by default.
- **Defined:**
  - Port ovf exists.
  - Carry-in to the MSB is recovered as c_msb = a[W-1] ^ b[W-1] ^ s[W-1].
  - ovf = c_msb ^ cout, registered on the final RUN edge alongside s.
  - ovf is valid with out_valid and resets to 0.
- **Undefined:** port ovf and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x12, b=0x34, cin=0.
  - Expect s=0x46 and cout=0, with out_valid exactly 4 cycles after acceptance.
- WIDTH=8, a=0xFF, b=0x01, cin=0.
  - Expect s=0x00 and cout=1; the carry must ripple through all 4 digits.
  - With CLA_SERIAL_OVF_EN, expect ovf=0.
- WIDTH=8, a=0x7F, b=0x00, cin=1.
  - Expect s=0x80, cout=0 and ovf=1 (with macro).
  - Also a=0x80, b=0x80, cin=0: expect s=0x00, cout=1, ovf=1.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles in DONE. Expect s/cout stable and in_ready=0 throughout.
  - Assert in_valid with new operands meanwhile; they must not be accepted.
  - Release out_ready. Expect IDLE on the next cycle, then the new pair is accepted.
- Reset mid-RUN:
  - Accept a=0xAA, b=0x55, cin=1, then drive rst_n=0 on the 2nd RUN cycle.
  - Expect out_valid=0, s=0, cout=0 and in_ready=1 after reset is released.
  - A fresh 0x01+0x01 must then yield s=0x02.
- Random soak, WIDTH=16, 1000 transactions, random in_valid/out_ready stalls.
  - Every {cout,s} must equal a+b+cin, in order.
  - No transaction may be lost or duplicated.
